// File: rtl/rf_write_sched.sv
// rf_write_sched: write-port scheduler for the bitcell register file.
// Arbitrates the single write port between pipeline writeback (A) and the
// secondary writer (B), and turns LLB/LHB byte writes into a read-modify-write
// through read port 2 (RD cycle, then merged write in MWR).
// Optional build macro: RF_SCHED_FIXED_PRIO_EN (A always wins a tie; otherwise
// round-robin on the last granted requester).
module rf_write_sched #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [$clog2(NREG)-1:0] a_addr,
    input  logic [DATA_W-1:0]       a_data,
    input  logic [1:0]              a_half,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [$clog2(NREG)-1:0] b_addr,
    input  logic [DATA_W-1:0]       b_data,
    input  logic [1:0]              b_half,
    output logic                    rf_rd_en,
    output logic [NREG-1:0]         rf_rd_sel,
    input  logic [DATA_W-1:0]       rf_rd_data,
    output logic [NREG-1:0]         rf_wsel,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic                    rf_load_half,
    output logic                    busy
);
    localparam int AW = $clog2(NREG);
    localparam int HW = DATA_W / 2;

    typedef enum logic [1:0] {IDLE, WR, RD, MWR} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [HW-1:0]   byte_q, byte_d;
    logic            lhb_q, lhb_d;
    logic            rd_en_q, rd_en_d;
    logic [NREG-1:0] rd_sel_q, rd_sel_d;
    logic [NREG-1:0] wsel_q, wsel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic            load_half_q, load_half_d;
`ifndef RF_SCHED_FIXED_PRIO_EN
    logic            last_b_q, last_b_d;
`endif

    logic              win_a, hs, req_rmw;
    logic [AW-1:0]     req_addr;
    logic [DATA_W-1:0] req_data;
    logic [1:0]        req_half;

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
        logic [NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Grant selection; nothing is accepted in reset or while read port 2 is busy
    always_comb begin
`ifdef RF_SCHED_FIXED_PRIO_EN
        win_a = a_valid;
`else
        win_a = a_valid && (!b_valid || last_b_q);
`endif
        a_ready  = rst && (state_q != RD) && win_a;
        b_ready  = rst && (state_q != RD) && b_valid && !win_a;
        hs       = a_ready || b_ready;
        req_addr = a_ready ? a_addr : b_addr;
        req_data = a_ready ? a_data : b_data;
        req_half = a_ready ? a_half : b_half;
        // R0 never needs the merge: it is hardwired zero
        req_rmw  = ((req_half == 2'b01) || (req_half == 2'b10)) && (req_addr != '0);
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = IDLE;
        addr_d      = addr_q;
        byte_d      = byte_q;
        lhb_d       = lhb_q;
        rd_en_d     = 1'b0;
        rd_sel_d    = '0;
        wsel_d      = '0;
        wdata_d     = '0;
        load_half_d = 1'b0;
        if (state_q == RD) begin
            // rf_rd_data is the pre-write register value; merge the new byte in
            state_d     = MWR;
            wsel_d      = onehot(addr_q);
            load_half_d = 1'b1;
            wdata_d     = lhb_q ? {byte_q, rf_rd_data[HW-1:0]}
                                : {rf_rd_data[DATA_W-1:HW], byte_q};
        end else if (hs) begin
            addr_d = req_addr;
            byte_d = req_data[HW-1:0];
            lhb_d  = (req_half == 2'b10);
            if (req_rmw) begin
                state_d     = RD;
                rd_en_d     = 1'b1;
                rd_sel_d    = onehot(req_addr);
                load_half_d = 1'b1;
            end else begin
                state_d = WR;
                wsel_d  = (req_addr == '0) ? '0 : onehot(req_addr);
                wdata_d = req_data;
            end
        end
    end

`ifndef RF_SCHED_FIXED_PRIO_EN
    // Remember who won the last handshake for round-robin
    always_comb begin
        last_b_d = hs ? b_ready : last_b_q;
    end
`endif

    // State and output registers; reset aborts any in-flight RMW
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            byte_q      <= '0;
            lhb_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_sel_q    <= '0;
            wsel_q      <= '0;
            wdata_q     <= '0;
            load_half_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            byte_q      <= byte_d;
            lhb_q       <= lhb_d;
            rd_en_q     <= rd_en_d;
            rd_sel_q    <= rd_sel_d;
            wsel_q      <= wsel_d;
            wdata_q     <= wdata_d;
            load_half_q <= load_half_d;
        end
    end

`ifndef RF_SCHED_FIXED_PRIO_EN
    // Round-robin pointer; starts at B so A wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_b_q <= 1'b1;
        else      last_b_q <= last_b_d;
    end
`endif

    assign rf_rd_en     = rd_en_q;
    assign rf_rd_sel    = rd_sel_q;
    assign rf_wsel      = wsel_q;
    assign rf_wdata     = wdata_q;
    assign rf_load_half = load_half_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_rf_write_sched.sv
// Bench for rf_write_sched: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model (slot schedule + shadow RF).
module tb_rf_write_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 0, b_valid = 0;
    logic        a_ready, b_ready;
    logic [3:0]  a_addr = 0, b_addr = 0;
    logic [15:0] a_data = 0, b_data = 0;
    logic [1:0]  a_half = 0, b_half = 0;
    logic        rf_rd_en, rf_load_half, busy;
    logic [15:0] rf_rd_sel, rf_rd_data, rf_wsel, rf_wdata;

    always #5 clk = ~clk;

    rf_write_sched #(.DATA_W(16), .NREG(16)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data), .a_half(a_half),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data), .b_half(b_half),
        .rf_rd_en(rf_rd_en), .rf_rd_sel(rf_rd_sel), .rf_rd_data(rf_rd_data),
        .rf_wsel(rf_wsel), .rf_wdata(rf_wdata), .rf_load_half(rf_load_half), .busy(busy)
    );

    // Environment register file (written from DUT outputs) and model copy
    logic [15:0] rf   [16];
    logic [15:0] mref [16];

    always_comb begin
        rf_rd_data = '0;
        for (int i = 0; i < 16; i++) if (rf_rd_sel[i]) rf_rd_data |= rf[i];
    end

    localparam int K_IDLE = 0, K_WR = 1, K_RD = 2, K_MWR = 3;
    typedef struct {
        int          k;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        lhb;
    } slot_t;

    slot_t cur;
    bit    last_b;
    int    tests = 0, fails = 0;
    bit    ga_hist[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: compare this cycle's outputs with the model, advance the model
    task automatic step();
        logic [15:0] ew, ewd, ers, wr_sel, wr_dat;
        logic        ere, elh, eb, wa, acc, ear, ebr;
        logic [1:0]  h;
        @(negedge clk);
        if (!rst) begin
            cur.k  = K_IDLE;
            last_b = 1'b1;
        end
        ew = '0; ewd = '0; ers = '0; ere = 0; elh = 0;
        eb = (cur.k != K_IDLE);
        case (cur.k)
            K_WR:  begin if (cur.addr != 0) ew = 16'(1) << cur.addr; ewd = cur.data; end
            K_RD:  begin ere = 1; ers = 16'(1) << cur.addr; elh = 1; end
            K_MWR: begin
                ew  = 16'(1) << cur.addr;
                elh = 1;
                ewd = cur.lhb ? {cur.data[7:0], mref[cur.addr][7:0]}
                              : {mref[cur.addr][15:8], cur.data[7:0]};
            end
            default: ;
        endcase
        chk("wsel", 32'(rf_wsel), 32'(ew));
        if (ew != 0) chk("wdata", 32'(rf_wdata), 32'(ewd));
        chk("rd_en", 32'(rf_rd_en), 32'(ere));
        chk("rd_sel", 32'(rf_rd_sel), 32'(ers));
        chk("load_half", 32'(rf_load_half), 32'(elh));
        chk("busy", 32'(busy), 32'(eb));
`ifdef RF_SCHED_FIXED_PRIO_EN
        wa = a_valid;
`else
        wa = a_valid && (!b_valid || last_b);
`endif
        acc = rst && (cur.k != K_RD);
        ear = acc && wa;
        ebr = acc && b_valid && !wa;
        chk("a_ready", 32'(a_ready), 32'(ear));
        chk("b_ready", 32'(b_ready), 32'(ebr));
        ga_hist.push_back(a_ready);
        wr_sel = rf_wsel;
        wr_dat = rf_wdata;
        if (ew != 0) mref[cur.addr] = ewd;
        if (cur.k == K_RD) cur.k = K_MWR;
        else if (ear || ebr) begin
            h        = ear ? a_half : b_half;
            cur.addr = ear ? a_addr : b_addr;
            cur.data = ear ? a_data : b_data;
            cur.lhb  = (h == 2'b10);
            cur.k    = ((h == 2'b01 || h == 2'b10) && cur.addr != 0) ? K_RD : K_WR;
            last_b   = ebr;
        end else cur.k = K_IDLE;
        @(posedge clk);
        #1;
        for (int i = 1; i < 16; i++) if (wr_sel[i]) rf[i] = wr_dat;
    endtask

    task automatic set_a(input logic v, input logic [3:0] ad, input logic [15:0] d, input logic [1:0] h);
        a_valid = v; a_addr = ad; a_data = d; a_half = h;
    endtask

    task automatic set_b(input logic v, input logic [3:0] ad, input logic [15:0] d, input logic [1:0] h);
        b_valid = v; b_addr = ad; b_data = d; b_half = h;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] old;
        for (int i = 0; i < 16; i++) begin
            rf[i]   = (i == 0) ? 16'h0 : 16'($urandom);
            mref[i] = rf[i];
        end
        cur.k = K_IDLE; cur.addr = 0; cur.data = 0; cur.lhb = 0;
        last_b = 1'b1;

        // Reset held with both requesters valid
        set_a(1, 4'd1, 16'h1111, 2'b00);
        set_b(1, 4'd2, 16'h2222, 2'b00);
        @(posedge clk); #1;
        step();
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_wsel", 32'(rf_wsel), 32'd0);
        chk("rst_wdata", 32'(rf_wdata), 32'd0);
        step();
        rst = 1'b1; #1;
        chk("first_grant_a", 32'(a_ready), 32'd1);
        chk("first_grant_b", 32'(b_ready), 32'd0);
        step();
        set_a(0, 0, 0, 0);
        step();
        set_b(0, 0, 0, 0);
        step();

        // Full write R5 = BEEF, visible for exactly one cycle
        set_a(1, 4'd5, 16'hBEEF, 2'b00);
        step();
        set_a(0, 0, 0, 0);
        chk("full_wsel", 32'(rf_wsel), 32'h0020);
        chk("full_wdata", 32'(rf_wdata), 32'hBEEF);
        step();
        chk("full_one_cycle", 32'(rf_wsel), 32'h0);

        // R3 = 1234, then LLB AB -> 12AB, LHB CD -> CDAB
        set_a(1, 4'd3, 16'h1234, 2'b00);
        step();
        set_a(0, 0, 0, 0);
        step();
        set_a(1, 4'd3, 16'h00AB, 2'b01);
        step();
        set_a(0, 0, 0, 0);
        chk("llb_rd_sel", 32'(rf_rd_sel), 32'h0008);
        chk("llb_rd_lh", 32'(rf_load_half), 32'd1);
        chk("llb_rd_wsel", 32'(rf_wsel), 32'h0);
        step();
        chk("llb_mwr_wsel", 32'(rf_wsel), 32'h0008);
        chk("llb_mwr_wdata", 32'(rf_wdata), 32'h12AB);
        step();
        chk("llb_r3", 32'(rf[3]), 32'h12AB);
        set_a(1, 4'd3, 16'h00CD, 2'b10);
        step();
        set_a(0, 0, 0, 0);
        step();
        step();
        chk("lhb_r3", 32'(rf[3]), 32'hCDAB);

        // Contention: both valid with full writes every cycle
        set_a(1, 4'd6, 16'h6666, 2'b00);
        set_b(1, 4'd7, 16'h7777, 2'b00);
        ga_hist.delete();
        for (int i = 0; i < 4; i++) step();
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
`ifdef RF_SCHED_FIXED_PRIO_EN
            chk("contend_grant_a", 32'(ga_hist[i]), 32'd1);
`else
            chk("contend_grant_a", 32'(ga_hist[i]), 32'(i % 2));
`endif
        end
        step();
        step();

        // Half write to R0: WR path, no RD, no write enable
        set_b(1, 4'd0, 16'h00FF, 2'b01);
        step();
        set_b(0, 0, 0, 0);
        chk("r0_busy", 32'(busy), 32'd1);
        chk("r0_rd_en", 32'(rf_rd_en), 32'd0);
        chk("r0_wsel", 32'(rf_wsel), 32'h0);
        step();

        // A half write then B full write stalls through RD
        set_a(1, 4'd9, 16'h0012, 2'b01);
        step();
        set_a(0, 0, 0, 0);
        set_b(1, 4'd10, 16'h5555, 2'b00);
        #1;
        chk("stall_b_ready", 32'(b_ready), 32'd0);
        step();
        step();
        set_b(0, 0, 0, 0);
        chk("stall_b_wsel", 32'(rf_wsel), 32'h0400);
        chk("stall_b_wdata", 32'(rf_wdata), 32'h5555);
        step();

        // Reset during RD aborts the merged write
        set_a(1, 4'd11, 16'h00EE, 2'b10);
        step();
        set_a(0, 0, 0, 0);
        chk("abort_rd_en", 32'(rf_rd_en), 32'd1);
        old = rf[11];
        rst = 1'b0; #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_en0", 32'(rf_rd_en), 32'd0);
        step();
        rst = 1'b1;
        step();
        step();
        chk("abort_r11", 32'(rf[11]), 32'(old));

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            set_a($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom));
            set_b($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom));
            step();
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        for (int n = 0; n < 4; n++) step();
        for (int i = 0; i < 16; i++) chk($sformatf("final_r%0d", i), 32'(rf[i]), 32'(mref[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
